// File: rtl/sram_stream_reader.sv
// Streams a contiguous, wrapping SRAM address range out as valid/ready beats.
// Reads are credit-limited against the output FIFO so a returning word always has a slot.
module sram_stream_reader #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 2,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    output logic                  sram_chip_select,
    output logic                  sram_output_enable,
    input  logic [WIDTH-1:0]      sram_read_data,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   next_addr_reg;
    logic [ADDR_WIDTH:0]     remaining_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    cs_reg;
    logic                    done_reg, done_next;
    logic                    load;
    logic [READ_LATENCY-1:0] pipe_reg, pipe_next;
    logic [INF_W-1:0]        inflight;

    logic [WIDTH-1:0]        fifo_mem [BUF_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]        count_reg, count_next;

    logic push, pop, issue, credit_ok, fifo_drains;

    assign out_valid          = (count_reg != '0);
    assign out_data           = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign pop                = out_valid && out_ready;
    assign push               = pipe_reg[READ_LATENCY-1];
    assign busy               = (state_reg != ST_IDLE);
    assign done               = done_reg;
    assign sram_read_address  = addr_reg;
    assign sram_chip_select   = cs_reg;
    assign sram_output_enable = cs_reg;

    // Bit k marks a request presented k cycles ago; the top bit tags the capture cycle.
    assign pipe_next[0] = issue;
    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe_reg[i]);
        end
    end

    // A beat leaving this cycle already frees its slot for a new request.
    assign credit_ok   = (int'(inflight) + int'(count_reg) - int'(pop)) < BUF_DEPTH;
    assign issue       = (state_reg == ST_RUN) && (remaining_reg != '0) && credit_ok;
    assign fifo_drains = (count_reg == '0) || ((count_reg == CNT_W'(1)) && pop);

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_next = ST_RUN;
                        load       = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue && (remaining_reg == (ADDR_WIDTH+1)'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((pipe_reg == '0) && fifo_drains) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            next_addr_reg <= '0;
            remaining_reg <= '0;
            addr_reg      <= '0;
            cs_reg        <= 1'b0;
            done_reg      <= 1'b0;
            pipe_reg      <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            cs_reg    <= issue;
            pipe_reg  <= pipe_next;
            count_reg <= count_next;
            if (load) begin
                next_addr_reg <= base_address;
                remaining_reg <= length;
            end else if (issue) begin
                next_addr_reg <= (next_addr_reg == LAST_ADDR) ? '0 : next_addr_reg + 1'b1;
                remaining_reg <= remaining_reg - 1'b1;
            end
            if (issue) begin
                addr_reg <= next_addr_reg;
            end
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage only; occupancy and pointers carry the reset state.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sram_read_data;
        end
    end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side client for the team's dual-port SRAM.
- On a start command it fetches a contiguous, wrapping address range through the SRAM read port and emits the words as a valid/ready stream, in address order.
- It absorbs the SRAM's fixed read latency with credit-limited issue and an output buffer, so beats are never lost under backpressure.
- It sits between the SRAM read port and downstream consumers such as DMA or streaming datapaths.

Parameters:
- WIDTH, 32, data word width; must match the SRAM.
- DEPTH, 16, SRAM word count; addresses wrap modulo DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- READ_LATENCY, 2, cycles from request presented to data sampled; must be ≥1.
- BUF_DEPTH, 4, output buffer entries; full throughput requires ≥ READ_LATENCY+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle command pulse.
- base_address  input  ADDR_WIDTH  first address; sampled with start.
- length  input  ADDR_WIDTH+1  word count, 0..DEPTH; sampled with start.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when transfer completes.
- sram_read_address  output  ADDR_WIDTH  SRAM read address.
- sram_chip_select  output  1  SRAM chip select.
- sram_output_enable  output  1  SRAM output enable.
- sram_read_data  input  WIDTH  SRAM read data.
- out_data  output  WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE.
  - Buffer empty; in-flight pipeline cleared.
  - Reset asserted mid-transfer aborts immediately: no done pulse, and sampled SRAM data is discarded.
- FSM states:
  - IDLE: busy=0.
  - IDLE → RUN on start when length>0. Latch next_addr=base_address and remaining=length.
  - IDLE → IDLE on start when length==0; done=1 on the next cycle, no SRAM access.
  - RUN: busy=1. Issues reads. When remaining reaches 0 → DRAIN.
  - DRAIN: busy=1. No new reads. When in-flight==0, buffer empty and no beat is transferring → IDLE, with done=1 for one cycle. done coincides with busy falling.
  - start while busy=1 is ignored; no state change.
- Issue rule:
  - A read is issued in a cycle when state is RUN, remaining>0 and (in-flight + buffer occupancy) < BUF_DEPTH.
  - Occupancy counts beats popped in the same cycle as already freed.
- Issue effects:
  - On issue, the registered outputs present sram_read_address=next_addr and sram_chip_select=sram_output_enable=1 for exactly that cycle; otherwise both are 0 and the address holds.
  - next_addr increments modulo DEPTH (DEPTH-1 → 0). remaining decrements.
- Read latency:
  - A request presented in cycle t returns data sampled by the reader at the edge ending cycle t+READ_LATENCY-1.
  - This is tracked with a READ_LATENCY-deep valid shift register.
  - sram_read_data is captured only on tagged cycles; the value on other cycles is don't-care (may be X).
- Output buffer:
  - FIFO of BUF_DEPTH entries; out_valid = buffer non-empty; out_data = head entry.
  - Beat transfers when out_valid && out_ready. Simultaneous push and pop are allowed at any occupancy, including full.
  - out_data is stable while out_valid && !out_ready.
  - Credits guarantee a push never hits a full buffer.
- Throughput: with out_ready held at 1 and BUF_DEPTH ≥ READ_LATENCY+1, one beat per cycle after the initial latency.
- Ordering: beats leave in issue order; no duplicates, no drops.

Test Plan:
- Bench model of the SRAM with READ_LATENCY=2; mem[i]=32'hA5000000+i.
- Full sweep: start with base 0, length 16, out_ready=1 → 16 consecutive beats A5000000..A500000F. First out_valid appears 4 edges after start. done pulses once, the cycle after the last transfer.
- Wrap-around: base 14, length 4 → beats A500000E, A500000F, A5000000, A5000001. Address sequence 14, 15, 0, 1.
- Backpressure: base 0, length 16; out_ready=0 for cycles 0..11, then alternates 1/0.
  - Never more than 4 reads outstanding plus buffered.
  - out_data stable during stalls.
  - All 16 values arrive in order.
- Zero length: start with length 0 → done=1 on the next cycle; busy, sram_chip_select and out_valid stay 0.
- Start while busy: second start (base 8, length 2) during a base 0, length 6 transfer → ignored. Exactly 6 beats A5000000..A5000005 and one done pulse.
- Reset mid-transfer: drop rst_n after 3 beats → all outputs 0 immediately. After release, base 3, length 2 yields A5000003, A5000004 only.
